// File: rtl/lc_transition_initiator_if.sv
// ---------------------------------------------------------------------------
// lc_transition_initiator_if
//
// Groups the host command/status channel and the lifecycle responder
// handshake that the transition initiator sits between.
//
//   master : the initiator (drives request, identifier, status)
//   slave  : the environment (host + lifecycle responder)
//
// Signals
//   cmd_valid / cmd_ready          host command handshake
//   cmd_target [ST_W]              requested next lifecycle state
//   cmd_identifier [ID_W]          owner identifier for the transition
//   lc_state [ST_W]                current lifecycle state from responder
//   lc_done / lc_success           responder completion and result
//   lc_transition_request          request to responder (4-phase)
//   lc_identifier [ID_W]           identifier presented to responder
//   rsp_valid / rsp_ready          host status handshake
//   rsp_status [2]                 0 OK, 1 AUTH_FAIL, 2 TIMEOUT, 3 REJECTED
//   fail_count [2]                 saturating AUTH_FAIL counter
//   locked                         lockout active
// ---------------------------------------------------------------------------
interface lc_transition_initiator_if #(
  parameter int ID_W = 256,
  parameter int ST_W = 3
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [ST_W-1:0] cmd_target;
  logic [ID_W-1:0] cmd_identifier;
  logic [ST_W-1:0] lc_state;
  logic            lc_done;
  logic            lc_success;
  logic            lc_transition_request;
  logic [ID_W-1:0] lc_identifier;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_status;
  logic [1:0]      fail_count;
  logic            locked;

  modport master (
    input  cmd_valid, cmd_target, cmd_identifier, lc_state, lc_done,
           lc_success, rsp_ready,
    output cmd_ready, lc_transition_request, lc_identifier, rsp_valid,
           rsp_status, fail_count, locked
  );

  modport slave (
    output cmd_valid, cmd_target, cmd_identifier, lc_state, lc_done,
           lc_success, rsp_ready,
    input  cmd_ready, lc_transition_request, lc_identifier, rsp_valid,
           rsp_status, fail_count, locked
  );
endinterface

// File: rtl/lc_transition_initiator.sv
// ---------------------------------------------------------------------------
// lc_transition_initiator
//
// Requester side of the lifecycle transition handshake. Accepts a host
// command (target state + owner identifier), checks single-step legality,
// runs a 4-phase request/done handshake with the lifecycle responder and
// returns a status word to the host.
//
// Ports
//   clk   : clock
//   rst   : asynchronous, active-low reset
//   bus   : lc_transition_initiator_if.master (command, responder and
//           status signals, see the interface file)
//
// Optional feature
//   LC_INIT_LOCKOUT_EN : when defined, a response that completes while
//   fail_count == MAX_FAIL moves the block into a LOCKED state that
//   rejects every further command until reset. When undefined the LOCKED
//   state does not exist and locked is tied to 0.
// ---------------------------------------------------------------------------
module lc_transition_initiator #(
  parameter int              ID_W           = 256,
  parameter int              ST_W           = 3,
  parameter logic [ST_W-1:0] LC_MAX         = 3'd5,
  parameter int              TIMEOUT_CYCLES = 1024,
  parameter int              MAX_FAIL       = 3
) (
  input logic                        clk,
  input logic                        rst,
  lc_transition_initiator_if.master  bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE,
    S_RESP
`ifdef LC_INIT_LOCKOUT_EN
    , S_LOCKED
`endif
  } state_e;

  typedef enum logic [1:0] {
    RSP_OK        = 2'd0,
    RSP_AUTH_FAIL = 2'd1,
    RSP_TIMEOUT   = 2'd2,
    RSP_REJECTED  = 2'd3
  } status_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  status_e          status_q, status_d;
  logic [1:0]       fail_q, fail_d;
  // Set when the responder was still holding lc_done at release expiry;
  // blocks the next request until lc_done has been seen low.
  logic             stale_q, stale_d;
  logic             cmd_legal;

`ifdef LC_INIT_LOCKOUT_EN
  logic             locked_q, locked_d;
`else
  logic [31:0]      unused_max_fail;
  assign unused_max_fail = MAX_FAIL;
`endif

  // Legality is judged on the values being captured at acceptance, so a
  // legal command can raise the request on the very next cycle.
  assign cmd_legal = (bus.lc_state < LC_MAX) &&
                     (bus.cmd_target == bus.lc_state + ST_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    status_d = status_q;
    fail_d   = fail_q;
    stale_d  = stale_q;
`ifdef LC_INIT_LOCKOUT_EN
    locked_d = locked_q;
`endif
    if (!bus.lc_done) begin
      stale_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (cmd_legal) begin
            id_d    = bus.cmd_identifier;
            cnt_d   = '0;
            state_d = S_REQ;
          end else begin
            status_d = RSP_REJECTED;
            state_d  = S_RESP;
          end
        end
      end

      S_REQ: begin
        if (bus.lc_done && !stale_q) begin
          cnt_d   = '0;
          id_d    = '0;
          state_d = S_RELEASE;
          if (bus.lc_success) begin
            status_d = RSP_OK;
            fail_d   = 2'd0;
          end else begin
            status_d = RSP_AUTH_FAIL;
            fail_d   = (fail_q == 2'd3) ? fail_q : fail_q + 2'd1;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          id_d     = '0;
          status_d = RSP_TIMEOUT;
          state_d  = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RELEASE: begin
        if (!bus.lc_done) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          status_d = RSP_TIMEOUT;
          stale_d  = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
`ifdef LC_INIT_LOCKOUT_EN
          if (locked_q || (fail_q == 2'(MAX_FAIL))) begin
            locked_d = 1'b1;
            state_d  = S_LOCKED;
          end
`endif
        end
      end

`ifdef LC_INIT_LOCKOUT_EN
      S_LOCKED: begin
        if (bus.cmd_valid) begin
          status_d = RSP_REJECTED;
          state_d  = S_RESP;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      id_q     <= '0;
      status_q <= RSP_OK;
      fail_q   <= 2'd0;
      stale_q  <= 1'b0;
`ifdef LC_INIT_LOCKOUT_EN
      locked_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      status_q <= status_d;
      fail_q   <= fail_d;
      stale_q  <= stale_d;
`ifdef LC_INIT_LOCKOUT_EN
      locked_q <= locked_d;
`endif
    end
  end

  // Outputs decode directly from registered state so the asynchronous
  // reset drops the request and identifier immediately.
`ifdef LC_INIT_LOCKOUT_EN
  assign bus.cmd_ready = (state_q == S_IDLE) || (state_q == S_LOCKED);
  assign bus.locked    = locked_q;
`else
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.locked    = 1'b0;
`endif
  assign bus.lc_transition_request = (state_q == S_REQ) && !stale_q;
  assign bus.lc_identifier         = id_q;
  assign bus.rsp_valid             = (state_q == S_RESP);
  assign bus.rsp_status            = status_q;
  assign bus.fail_count            = fail_q;

endmodule

// File: tb/tb_lc_transition_initiator.sv
module tb_lc_transition_initiator;
  localparam int ID_W = 256;
  localparam int ST_W = 3;
  localparam int T    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lc_transition_initiator_if #(.ID_W(ID_W), .ST_W(ST_W)) lc_bus ();

  lc_transition_initiator #(
    .ID_W(ID_W), .ST_W(ST_W), .LC_MAX(3'd5), .TIMEOUT_CYCLES(T), .MAX_FAIL(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(lc_bus)
  );

  // Expected outputs for the current cycle, written by the driver only.
  bit              chk_en = 1'b0;
  int              cur_t = -1;
  logic            exp_cmd_ready, exp_req, exp_rsp_valid, exp_locked;
  logic [1:0]      exp_status, exp_fail;
  logic [ID_W-1:0] exp_id;
  int              lit_first_rsp = -1, lit_status = -1, lit_fail = -1, lit_req_cnt = -1;

  // Reference state across transactions.
  logic [1:0]      fail_m = 2'd0;
  bit              locked_m = 1'b0;

  // Written by the compare process only.
  int checks = 0;
  int errors = 0;
  int obs_req_cnt = 0;
  bit obs_rsp_seen = 1'b0;

  task automatic check(input string name, input logic [ID_W-1:0] act, input logic [ID_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, cur_t, act, exp);
    end
  endtask

  // Single compare process: every cycle, DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (cur_t == 0) begin
          obs_req_cnt  = 0;
          obs_rsp_seen = 1'b0;
        end
        check("cmd_ready", lc_bus.cmd_ready, exp_cmd_ready);
        check("lc_transition_request", lc_bus.lc_transition_request, exp_req);
        check("lc_identifier", lc_bus.lc_identifier, exp_id);
        check("rsp_valid", lc_bus.rsp_valid, exp_rsp_valid);
        check("fail_count", lc_bus.fail_count, exp_fail);
        check("locked", lc_bus.locked, exp_locked);
        if (exp_rsp_valid) check("rsp_status", lc_bus.rsp_status, exp_status);
        if (lc_bus.lc_transition_request) obs_req_cnt++;
        if (lc_bus.rsp_valid && !obs_rsp_seen && cur_t >= 0) begin
          obs_rsp_seen = 1'b1;
          if (lit_first_rsp >= 0) check("lit_first_rsp_cycle", cur_t, lit_first_rsp);
          if (lit_status >= 0)    check("lit_status", lc_bus.rsp_status, lit_status);
          if (lit_fail >= 0)      check("lit_fail_count", lc_bus.fail_count, lit_fail);
          if (lit_req_cnt >= 0)   check("lit_request_cycles", obs_req_cnt, lit_req_cnt);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [ID_W-1:0] rand_id();
    logic [ID_W-1:0] v;
    for (int i = 0; i < ID_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_lit(input int first_rsp, input int status, input int fail, input int req_cnt);
    lit_first_rsp = first_rsp;
    lit_status    = status;
    lit_fail      = fail;
    lit_req_cnt   = req_cnt;
  endtask

  task automatic set_exp_idle();
    exp_cmd_ready = 1'b1;
    exp_req       = 1'b0;
    exp_id        = '0;
    exp_rsp_valid = 1'b0;
    exp_status    = 2'd0;
    exp_fail      = fail_m;
    exp_locked    = locked_m;
  endtask

  // Entered at posedge+1; asserts reset mid-cycle, returns at posedge+1.
  task automatic do_reset(input int cycles);
    #1;
    rst = 1'b0;
    cur_t = -1;
    lc_bus.cmd_valid = 1'b0;
    lc_bus.lc_done   = 1'b0;
    fail_m   = 2'd0;
    locked_m = 1'b0;
    set_exp_idle();
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cur_t = -1;
      lc_bus.cmd_valid  = 1'b0;
      lc_bus.lc_done    = 1'($urandom_range(0, 1));
      lc_bus.rsp_ready  = 1'($urandom_range(0, 1));
      lc_bus.lc_state   = 3'($urandom);
      set_exp_idle();
      @(posedge clk);
      #1;
    end
  endtask

  // One host command. Cycle 0 presents the command; the responder raises
  // lc_done d cycles into the request (d >= T: never) and holds it for len
  // cycles; the host keeps rsp_ready low for w cycles of the response.
  // The expected timeline is derived arithmetically from those choices.
  task automatic run_txn(input logic [2:0] st, input logic [2:0] tgt, input logic [ID_W-1:0] id,
                         input int d, input bit succ, input int len, input int w, input int rst_at);
    bit         legal, go, cap, locked_new;
    int         req_end, r, k, s, hs, ds, de, fin;
    logic [1:0] status, fail_new;
    legal    = (st < 3'd5) && (tgt == 3'(st + 3'd1));
    go       = legal && !locked_m;
    cap      = go && (d < T);
    fail_new = fail_m;
    req_end  = 0;
    if (!go) begin
      s = 1; status = 2'd3; ds = 1; de = 2;          // lc_done noise, must be ignored
    end else begin
      if (cap) begin
        req_end = 1 + d; r = 2 + d; k = len - 1; ds = 1 + d; de = 1 + d + len;
        status   = succ ? 2'd0 : 2'd1;
        fail_new = succ ? 2'd0 : ((fail_m == 2'd3) ? 2'd3 : fail_m + 2'd1);
      end else begin
        req_end = T; r = T + 1; k = 0; ds = 0; de = 0; status = 2'd2;
      end
      if (k < T) s = r + k + 1;
      else begin
        s = r + T; status = 2'd2;
      end
    end
    hs  = s + w;
    fin = (hs + 1 > de) ? hs + 1 : de;
    locked_new = locked_m;
`ifdef LC_INIT_LOCKOUT_EN
    if (fail_new == 2'd3) locked_new = 1'b1;
`endif
    for (int t = 0; t < fin; t++) begin
      cur_t = t;
      lc_bus.cmd_valid      = (t == 0) ? 1'b1 : ((t <= hs) ? 1'($urandom_range(0, 1)) : 1'b0);
      lc_bus.cmd_target     = (t == 0) ? tgt : 3'($urandom);
      lc_bus.cmd_identifier = (t == 0) ? id : rand_id();
      lc_bus.lc_state       = st;
      lc_bus.lc_done        = (t >= ds) && (t < de);
      lc_bus.lc_success     = ((t >= ds) && (t < de)) ? succ : 1'($urandom_range(0, 1));
      lc_bus.rsp_ready      = (t == hs) ? 1'b1 : (((t >= s) && (t < hs)) ? 1'b0 : 1'($urandom_range(0, 1)));
      exp_cmd_ready = (t == 0) || (t > hs);
      exp_req       = go && (t >= 1) && (t <= req_end);
      exp_id        = exp_req ? id : '0;
      exp_rsp_valid = (t >= s) && (t <= hs);
      exp_status    = status;
      exp_fail      = (cap && (t >= 2 + d)) ? fail_new : fail_m;
      exp_locked    = (t > hs) ? locked_new : locked_m;
      if (t == rst_at) begin
        do_reset(2);
        return;
      end
      @(posedge clk);
      #1;
    end
    fail_m   = fail_new;
    locked_m = locked_new;
  endtask

  initial begin
    lc_bus.cmd_valid      = 1'b0;
    lc_bus.cmd_target     = '0;
    lc_bus.cmd_identifier = '0;
    lc_bus.lc_state       = '0;
    lc_bus.lc_done        = 1'b0;
    lc_bus.lc_success     = 1'b0;
    lc_bus.rsp_ready      = 1'b0;
    set_exp_idle();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset(3);                                   // reset values
    idle(2);

    // Legal 1->2, success after 2 cycles: request cycles 1..3, response at 5.
    set_lit(5, 0, 0, 3);  run_txn(3'd1, 3'd2, rand_id(), 2, 1'b1, 1, 0, -1);
    // Skip a state: rejected on cycle 1, no request.
    set_lit(1, 3, 0, 0);  run_txn(3'd1, 3'd3, rand_id(), 0, 1'b1, 1, 0, -1);
    // Out of end-of-life state.
    set_lit(1, 3, 0, 0);  run_txn(3'd5, 3'd6, rand_id(), 0, 1'b1, 1, 0, -1);
    // Auth failure, lc_done held 4 cycles: response at 6.
    set_lit(6, 1, 1, 1);  run_txn(3'd2, 3'd3, rand_id(), 0, 1'b0, 4, 0, -1);
    // Responder silent: 16 request cycles, response at 18.
    set_lit(18, 2, 1, 16); run_txn(3'd3, 3'd4, rand_id(), T, 1'b1, 1, 0, -1);
    // Host stalls rsp_ready for 10 cycles.
    set_lit(9, 0, 0, 6);  run_txn(3'd0, 3'd1, rand_id(), 5, 1'b1, 2, 10, -1);
    idle(1);
    // Three consecutive auth failures.
    set_lit(4, 1, 1, 2);  run_txn(3'd1, 3'd2, rand_id(), 1, 1'b0, 1, 0, -1);
    set_lit(4, 1, 2, 2);  run_txn(3'd1, 3'd2, rand_id(), 1, 1'b0, 1, 0, -1);
    set_lit(4, 1, 3, 2);  run_txn(3'd1, 3'd2, rand_id(), 1, 1'b0, 1, 0, -1);
`ifdef LC_INIT_LOCKOUT_EN
    set_lit(1, 3, 3, 0);
`else
    set_lit(4, 1, 3, 2);
`endif
    run_txn(3'd1, 3'd2, rand_id(), 1, 1'b0, 1, 0, -1);
    set_lit(-1, -1, -1, -1);
    idle(1);
    do_reset(2);                                   // clears fail_count / locked
    idle(1);
    run_txn(3'd1, 3'd2, rand_id(), T, 1'b1, 1, 0, 3);   // reset during request
    idle(1);
    // lc_done stuck past release bound: forced TIMEOUT at 18.
    set_lit(18, 2, 0, 1); run_txn(3'd4, 3'd5, rand_id(), 0, 1'b1, T + 2, 0, -1);
    set_lit(-1, -1, -1, -1);

    for (int n = 0; n < 250; n++) begin
      logic [2:0] st, tgt;
      int d, len, w, ra;
      st  = 3'($urandom_range(0, 7));
      tgt = ($urandom_range(0, 2) != 0) ? 3'(st + 3'd1) : 3'($urandom);
      d   = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, T - 1)) : T;
      len = ($urandom_range(0, 4) < 4) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, T + 3));
      w   = ($urandom_range(0, 4) < 4) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 12));
      ra  = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 10)) : -1;
      run_txn(st, tgt, rand_id(), d, 1'($urandom_range(0, 1)), len, w, ra);
      idle($urandom_range(0, 3));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lc_transition_initiator.md
Name: lc_transition_initiator

Overview:
- Requester side of the lifecycle transition handshake. Accepts a host or firmware transition command carrying the target state and a 256-bit owner identifier.
- Drives lc_transition_request / lc_identifier into the lifecycle protection responder, waits for lc_done / lc_success, then returns a status word to the host.
- Enforces single-step legality, a response timeout and a failed-attempt counter, with optional lockout.

Parameters:
- ID_W, 256, width of owner identifier.
- ST_W, 3, width of lifecycle state.
- LC_MAX, 3'd5, highest (end-of-life) state; no transition out of it.
- TIMEOUT_CYCLES, 1024, max cycles waited for each responder handshake edge.
- MAX_FAIL, 3, auth failures before lockout (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  block can accept command
- cmd_target  in  ST_W  requested next lifecycle state
- cmd_identifier  in  ID_W  owner identifier for this transition
- lc_state  in  ST_W  current lifecycle state from responder
- lc_done  in  1  responder completion
- lc_success  in  1  responder success, qualified by lc_done
- lc_transition_request  out  1  request to responder
- lc_identifier  out  ID_W  identifier to responder
- rsp_valid  out  1  status valid, held until rsp_ready
- rsp_ready  in  1  host accepts status
- rsp_status  out  2  0 OK, 1 AUTH_FAIL, 2 TIMEOUT, 3 REJECTED
- fail_count  out  2  saturating count of AUTH_FAIL results
- locked  out  1  lockout active

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1. FSM is IDLE; timeout counter is 0.
- FSM states: IDLE, REQ, RELEASE, RESP, LOCKED.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register cmd_target and cmd_identifier; cmd_ready drops the next cycle.
  - Legality check on the registered values: cmd_target == lc_state+1 and lc_state < LC_MAX.
  - Illegal: go to RESP with status REJECTED. No request is issued.
  - Legal: go to REQ and drive lc_identifier from the register.
- REQ:
  - lc_transition_request=1.
  - Timeout counter increments each cycle.
  - When lc_done=1, capture lc_success, clear the counter, go to RELEASE.
  - Status from capture: success=1 gives OK; success=0 gives AUTH_FAIL and fail_count increments, saturating at 3.
  - If the counter reaches TIMEOUT_CYCLES-1 without lc_done, status=TIMEOUT and go to RELEASE.
- RELEASE:
  - lc_transition_request=0.
  - Wait for lc_done=0, bounded by its own TIMEOUT_CYCLES count.
  - If lc_done is still high at expiry, force status=TIMEOUT.
  - Then go to RESP.
  - lc_identifier is zeroized on entry to RELEASE.
- RESP:
  - rsp_valid=1 with rsp_status stable until rsp_ready.
  - On the rsp_valid and rsp_ready cycle: go to IDLE, or to LOCKED if the lockout condition holds.
  - rsp_ready already high on the first RESP cycle gives a one-cycle response.
- LOCKED:
  - locked=1, cmd_ready=1.
  - Every command returns REJECTED via RESP, then back to LOCKED.
  - Exit only by reset.
- Latency, legal command to request: cmd_valid accepted (cycle 0), lc_transition_request high on cycle 1.
- OK resets fail_count to 0.
- lc_done arriving while in IDLE or RESP is ignored.
- cmd_valid while cmd_ready=0 is ignored; no command is queued.
- The request follows 4-phase rules: it never reasserts before lc_done has been observed low.
- Reset mid-operation: request and identifier drop asynchronously to 0. fail_count clears; persistent counting is out of scope.

Optional Feature:
- Macro: LC_INIT_LOCKOUT_EN.
- Defined: after a response completes with fail_count == MAX_FAIL, go to LOCKED as described above.
- Undefined: the LOCKED state is not built and locked is tied to 0. fail_count still counts and saturates, and the FSM always returns to IDLE.

Test Plan:
- lc_state=1, cmd_target=2, correct identifier -> request high on cycle 1. Responder done with success=1 -> rsp_status=0, fail_count=0, lc_identifier=0 after RELEASE.
- lc_state=1, cmd_target=3 -> no request pulse; rsp_status=3 within 2 cycles of acceptance.
- lc_state=5, cmd_target=6 -> rsp_status=3.
- Wrong identifier, responder done with success=0 -> rsp_status=1, fail_count=1. Request deasserted until lc_done=0, then back to IDLE.
- Responder never asserts done, TIMEOUT_CYCLES=16 -> request drops after 16 cycles in REQ; rsp_status=2.
- LC_INIT_LOCKOUT_EN defined, 3 consecutive auth failures -> locked=1; a 4th legal command returns rsp_status=3 with no request. Reset clears locked and fail_count.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_status held stable; cmd_ready=0 throughout.
- Assert rst during REQ -> lc_transition_request and lc_identifier go to 0 immediately; FSM returns to IDLE.
